// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the MEM stage (P) and the loader (L).
// Starvation-bounded arbitration, big-endian byte addressing, registered memory strobes.
module dmem_port_arbiter #(
  parameter int WORD_AW  = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p_req,
  input  logic               p_we,
  input  logic [WORD_AW-1:0] p_word,
  input  logic [31:0]        p_wdata,
  output logic               p_gnt,
  output logic               p_rvalid,
  input  logic               l_req,
  input  logic               l_we,
  input  logic [WORD_AW-1:0] l_word,
  input  logic [31:0]        l_wdata,
  output logic               l_gnt,
  output logic               l_rvalid,
  output logic [31:0]        rdata,
  output logic               busy,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_wdata,
  output logic               mem_read,
  output logic               mem_write,
  input  logic [31:0]        mem_rdata
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             owner_p0;  // 1 = L owns the current operation
  logic             we_p0;
  logic             p_win, l_win;
  logic             sel_we;
  logic [WORD_AW-1:0] sel_word;
  logic [31:0]      sel_wdata;

  // Word k lives at big-endian byte address 4k+3.
  function automatic logic [31:0] word_to_addr(input logic [WORD_AW-1:0] word);
    return {{(30-WORD_AW){1'b0}}, word, 2'b11};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    p_win    = 1'b0;
    l_win    = 1'b0;
    case (state_q)
      IDLE: begin
        l_win = l_req && (!p_req || starve_q == CNT_W'(MAX_WAIT));
        p_win = p_req && !l_win;
        if (l_win || !l_req)
          starve_d = '0;
        else if (p_win && starve_q != CNT_W'(MAX_WAIT))
          starve_d = starve_q + 1'b1;
        if (p_win || l_win)
          state_d = ISSUE;
      end
      ISSUE:   state_d = we_p0 ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign p_gnt     = p_win;
  assign l_gnt     = l_win;
  assign busy      = (state_q != IDLE);
  assign sel_we    = l_win ? l_we    : p_we;
  assign sel_word  = l_win ? l_word  : p_word;
  assign sel_wdata = l_win ? l_wdata : p_wdata;

  // Grant -> issue: latch the winner's request and present it to memory for one cycle.
  // Issue -> response: capture read data and pulse the owner's rvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_p0  <= 1'b0;
      we_p0     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rdata     <= '0;
      p_rvalid  <= 1'b0;
      l_rvalid  <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      p_rvalid  <= 1'b0;
      l_rvalid  <= 1'b0;
      if (p_win || l_win) begin
        owner_p0  <= l_win;
        we_p0     <= sel_we;
        mem_addr  <= word_to_addr(sel_word);
        mem_wdata <= sel_wdata;
        mem_read  <= !sel_we;
        mem_write <= sel_we;
      end
      if (state_q == ISSUE && !we_p0) begin
        rdata    <= mem_rdata;
        p_rvalid <= !owner_p0;
        l_rvalid <= owner_p0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized bench for dmem_port_arbiter with a word-array memory model
// and a transaction-level scoreboard of grant order and read data.
module tb_dmem_port_arbiter;

  localparam int WORD_AW  = 8;
  localparam int MAX_WAIT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         p_req = 1'b0, p_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [7:0]   p_word = '0, l_word = '0;
  logic [31:0]  p_wdata = '0, l_wdata = '0;
  logic         p_gnt, p_rvalid, l_gnt, l_rvalid, busy, mem_read, mem_write;
  logic [31:0]  rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0]  mem [256];
  logic [31:0]  ref_mem [256];
  int           n_chk = 0;
  int           n_fail = 0;
  int           losses = 0;
  int           who;

  dmem_port_arbiter #(.WORD_AW(WORD_AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_word(p_word), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid),
    .l_req(l_req), .l_we(l_we), .l_word(l_word), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: word k pre-loaded with 4k+4; the port addresses byte 4k+3.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(4 * i + 4);
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(4 * i + 4);
    losses = 0;
  endtask

  // Safety properties over the whole run.
  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_strobes", 32'(mem_read && mem_write), 32'h0);
      chk("inv_gnts", 32'(p_gnt && l_gnt), 32'h0);
      chk("inv_gnt_busy", 32'((p_gnt || l_gnt) && busy), 32'h0);
    end
  end

  // One arbitration plus the full operation it starts; called at posedge+1 in IDLE.
  task automatic op(output int w_who);
    int          exp;
    logic        we;
    logic [7:0]  wd;
    logic [31:0] data, expd;
    if (l_req && (!p_req || losses == MAX_WAIT)) exp = 2;
    else if (p_req) exp = 1;
    else exp = 0;
    if (exp == 1 && l_req) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
    else losses = 0;
    @(negedge clk);
    chk("p_gnt", 32'(p_gnt), 32'(exp == 1));
    chk("l_gnt", 32'(l_gnt), 32'(exp == 2));
    chk("busy_idle", 32'(busy), 32'h0);
    w_who = exp;
    if (exp == 0) begin
      @(posedge clk); #1;
      return;
    end
    we   = (exp == 2) ? l_we : p_we;
    wd   = (exp == 2) ? l_word : p_word;
    data = (exp == 2) ? l_wdata : p_wdata;
    expd = ref_mem[wd];
    if (we) ref_mem[wd] = data;
    @(posedge clk); #1;
    @(negedge clk);
    chk("issue_addr", mem_addr, {22'h0, wd, 2'b11});
    chk("issue_read", 32'(mem_read), 32'(!we));
    chk("issue_write", 32'(mem_write), 32'(we));
    if (we) chk("issue_wdata", mem_wdata, data);
    chk("issue_busy", 32'(busy), 32'h1);
    chk("issue_rvalid", 32'(p_rvalid || l_rvalid), 32'h0);
    @(posedge clk); #1;
    if (!we) begin
      @(negedge clk);
      chk("resp_p_rvalid", 32'(p_rvalid), 32'(exp == 1));
      chk("resp_l_rvalid", 32'(l_rvalid), 32'(exp == 2));
      chk("resp_rdata", rdata, expd);
      chk("resp_strobe", 32'(mem_read || mem_write), 32'h0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    ref_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_bits", {26'h0, p_gnt, l_gnt, p_rvalid, l_rvalid, busy, mem_read | mem_write}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // P read of word 2 straight after reset.
    p_req = 1'b1; p_we = 1'b0; p_word = 8'd2;
    op(who);
    chk("t1_who", 32'(who), 32'd1);
    p_req = 1'b0;

    // P write then read back word 5.
    p_req = 1'b1; p_we = 1'b1; p_word = 8'd5; p_wdata = 32'hDEADBEEF;
    op(who);
    p_we = 1'b0;
    op(who);
    chk("t2_who", 32'(who), 32'd1);
    p_req = 1'b0;

    // Both requesters held high: L forced through after MAX_WAIT losses.
    p_req = 1'b1; p_we = 1'b1; p_word = 8'd100; p_wdata = 32'h1111_0000;
    l_req = 1'b1; l_we = 1'b1; l_word = 8'd101; l_wdata = 32'h2222_0000;
    for (int i = 0; i < 8; i++) begin
      op(who);
      chk("t3_order", 32'(who), (i % 4 == 3) ? 32'd2 : 32'd1);
    end
    p_req = 1'b0; l_req = 1'b0;
    @(posedge clk); #1;

    // L alone reads word 0.
    l_req = 1'b1; l_we = 1'b0; l_word = 8'd0;
    op(who);
    chk("t4_who", 32'(who), 32'd2);
    l_req = 1'b0;

    // Reset asserted in the ISSUE cycle of a read.
    p_req = 1'b1; p_we = 1'b0; p_word = 8'd7;
    @(negedge clk);
    chk("t5_gnt", 32'(p_gnt), 32'h1);
    @(posedge clk); #1;
    chk("t5_issue_read", 32'(mem_read), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t5_read_drop", 32'(mem_read), 32'h0);
    chk("t5_busy_drop", 32'(busy), 32'h0);
    p_req = 1'b0;
    ref_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t5_no_rvalid", 32'(p_rvalid || l_rvalid), 32'h0);
    end
    @(posedge clk); #1;
    p_req = 1'b1;
    op(who);
    chk("t5_regrant", 32'(who), 32'd1);
    p_req = 1'b0;

    // Random traffic; a requester keeps its request until granted.
    for (int i = 0; i < 200; i++) begin
      if (!p_req && $urandom_range(0, 1) == 1) begin
        p_req = 1'b1; p_we = 1'($urandom_range(0, 1));
        p_word = 8'($urandom); p_wdata = $urandom;
      end
      if (!l_req && $urandom_range(0, 1) == 1) begin
        l_req = 1'b1; l_we = 1'($urandom_range(0, 1));
        l_word = 8'($urandom); l_wdata = $urandom;
      end
      op(who);
      if (who == 1) p_req = 1'b0;
      if (who == 2) l_req = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
